fifo_axis_reader: RTL
=====================

# fifo_axis_reader

Drains the BFM's synchronous FIFO from its read side and presents the data as an AXI4-Stream master. It issues FIFO reads (one-cycle registered read latency), buffers returned words in a 4-entry output queue so a stalled `m_axis_tready` never loses data, and frames the stream into fixed-length packets with `m_axis_tlast`. It sits between the FIFO's read port and the downstream AXI-Stream sink/checker.

## Interface
- `WIDTH`, 128: data width; matches the FIFO word width.
- `BURST_LEN`, 16: beats per packet; legal range 1..65535; `tlast` marks the final beat.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `enable` input 1: level; start/continue streaming when high.
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_rd_en` output 1: FIFO read request.
- `fifo_rd_data` input WIDTH: FIFO read data, valid the cycle after an accepted `fifo_rd_en`.
- `m_axis_tvalid` output 1: stream valid.
- `m_axis_tready` input 1: stream ready.
- `m_axis_tdata` output WIDTH: stream data.
- `m_axis_tlast` output 1: last beat of packet.
- `busy` output 1: state != IDLE or buffer/in-flight non-empty.
- `beat_count` output 32: beats accepted downstream (tvalid && tready), wraps mod 2^32.
- `pkt_count` output 16: packets completed (accepted beat with tlast), wraps mod 2^16.

## Operation
- States: IDLE, STREAM, STOPPING.
  - IDLE -> STREAM when `enable`=1.
  - STREAM -> STOPPING when `enable`=0 and issued-beat index != 0; STREAM -> IDLE when `enable`=0 and issued index == 0.
  - STOPPING -> IDLE when issued index returns to 0 (packet fully issued). Re-asserting `enable` in STOPPING is ignored until IDLE.
- Issued-beat index `iss_idx` (16 bit): increments on each `fifo_rd_en`, wraps BURST_LEN-1 -> 0.
- Read issue: `fifo_rd_en` = (state is STREAM or STOPPING) && !`fifo_empty` && (occ + inflight) <= 2, where occ = buffer entries (0..4) and inflight = read issued previous cycle (0/1). Never asserted while `fifo_empty`=1.
- Capture: when inflight=1, `fifo_rd_data` is written into the buffer tail that cycle.
- Output: `m_axis_tvalid` = (occ != 0); `m_axis_tdata` = buffer head; pop on tvalid && tready. Push and pop in the same cycle leave occ unchanged.
- Sent-beat index `snd_idx` (16 bit): increments on each accepted beat, wraps BURST_LEN-1 -> 0; `m_axis_tlast` = tvalid && (snd_idx == BURST_LEN-1). BURST_LEN=1: every beat has tlast.
- AXI rule: once tvalid=1, tdata/tlast held stable until accepted; tvalid never deasserts without handshake, including across `enable` falling.
- IDLE with data left in the buffer: buffer still drains to the sink; no new reads.
- FIFO starvation mid-packet: stream pauses (tvalid=0), packet resumes when FIFO refills; no padding.

## Timing
- Reset (async, `rst`=0): state IDLE; occ, inflight, iss_idx, snd_idx = 0; `fifo_rd_en`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy`=0, `beat_count`=0, `pkt_count`=0. Reset mid-packet discards buffered/in-flight data and restarts framing at beat 0.
- Latency: `fifo_rd_en` in cycle N -> data on `fifo_rd_data` cycle N+1 -> `m_axis_tvalid` first high cycle N+2.
- `enable` rise in cycle N -> state STREAM at N+1 -> first `fifo_rd_en` at N+1 (if FIFO non-empty) -> first tvalid at N+3.
- Throughput: with tready=1 and FIFO non-empty, one beat per cycle sustained after fill.
- Backpressure: tready=0 fills buffer to 4 entries max; `fifo_rd_en` stops at occ+inflight=3; no overflow.
- Counters update the cycle after the accepting edge.

## Test plan
- Preload FIFO with 32 words 0..31, BURST_LEN=16, enable=1, tready=1 -> 32 beats in order 0..31 on consecutive cycles, tlast on values 15 and 31, pkt_count=2, beat_count=32.
- Same preload, tready toggled 1/0 each cycle -> data order intact, no drop/duplicate, tdata/tlast stable while tvalid && !tready, occ never >4, fifo_rd_en never high with fifo_empty.
- 40 words, drop enable after 5 beats issued -> reads continue to beat 15, exactly 16 beats delivered (tlast on beat 15), state IDLE, 24 words remain in FIFO.
- FIFO holds 3 words, BURST_LEN=8 -> 3 beats then tvalid=0; push 5 more -> beats 3..7 follow, tlast on the 8th beat only.
- BURST_LEN=1, 4 words -> tlast on every beat, pkt_count=4.
- Assert rst low with 3 buffered words and tready=0 -> all outputs/counters at reset values immediately; after release, enable=1 restarts with snd_idx=0.

Source files
------------

// File: rtl/fifo_axis_reader.sv
// Reads a synchronous FIFO (one-cycle read latency) and presents its words as an
// AXI4-Stream master, framed into BURST_LEN-beat packets via a 4-entry skid queue.
module fifo_axis_reader #(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic [31:0]      beat_count,
  output logic [15:0]      pkt_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    STOPPING = 2'd2
  } state_e;

  localparam logic [15:0] LAST_IDX = 16'(BURST_LEN - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] buf_q [4];
  logic [1:0]       head_q, head_d;
  logic [1:0]       tail_q, tail_d;
  logic [2:0]       occ_q, occ_d;
  logic             inflight_q;
  logic [15:0]      iss_idx_q, iss_idx_d;
  logic [15:0]      snd_idx_q, snd_idx_d;
  logic [31:0]      beat_count_q, beat_count_d;
  logic [15:0]      pkt_count_q, pkt_count_d;

  logic             issue_ok_s;
  logic             rd_en_s;
  logic             push_s;
  logic             pop_s;
  logic             last_s;
  logic [2:0]       pending_s;

  // Next-state logic for the control FSM, queue pointers, beat indices and counters.
  always_comb begin
    push_s    = inflight_q;
    pop_s     = (occ_q != 3'd0) && m_axis_tready;
    last_s    = (snd_idx_q == LAST_IDX);
    pending_s = occ_q + {2'b00, inflight_q};

    // Reads are only issued while a packet can be completed: once enable drops,
    // only the remainder of the current packet is fetched.
    case (state_q)
      STREAM:   issue_ok_s = enable || (iss_idx_q != 16'd0);
      STOPPING: issue_ok_s = (iss_idx_q != 16'd0);
      default:  issue_ok_s = 1'b0;
    endcase

    rd_en_s = issue_ok_s && !fifo_empty && (pending_s <= 3'd2);

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (enable) begin
          state_d = STREAM;
        end else if (iss_idx_q != 16'd0) begin
          state_d = STOPPING;
        end else begin
          state_d = IDLE;
        end
      end
      STOPPING: begin
        if (iss_idx_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          state_d = STOPPING;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_en_s) begin
      iss_idx_d = (iss_idx_q == LAST_IDX) ? 16'd0 : iss_idx_q + 16'd1;
    end else begin
      iss_idx_d = iss_idx_q;
    end

    if (pop_s) begin
      snd_idx_d    = last_s ? 16'd0 : snd_idx_q + 16'd1;
      head_d       = head_q + 2'd1;
      beat_count_d = beat_count_q + 32'd1;
      pkt_count_d  = last_s ? pkt_count_q + 16'd1 : pkt_count_q;
    end else begin
      snd_idx_d    = snd_idx_q;
      head_d       = head_q;
      beat_count_d = beat_count_q;
      pkt_count_d  = pkt_count_q;
    end

    if (push_s) begin
      tail_d = tail_q + 2'd1;
    end else begin
      tail_d = tail_q;
    end

    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State, queue storage and counters; reset discards any buffered or in-flight word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      head_q       <= 2'd0;
      tail_q       <= 2'd0;
      occ_q        <= 3'd0;
      inflight_q   <= 1'b0;
      iss_idx_q    <= 16'd0;
      snd_idx_q    <= 16'd0;
      beat_count_q <= 32'd0;
      pkt_count_q  <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      inflight_q   <= rd_en_s;
      iss_idx_q    <= iss_idx_d;
      snd_idx_q    <= snd_idx_d;
      beat_count_q <= beat_count_d;
      pkt_count_q  <= pkt_count_d;
      if (push_s) begin
        buf_q[tail_q] <= fifo_rd_data;
      end
    end
  end

  // Stream outputs come straight from registered queue state, so they stay stable under stall.
  assign fifo_rd_en    = rd_en_s;
  assign m_axis_tvalid = (occ_q != 3'd0);
  assign m_axis_tdata  = buf_q[head_q];
  assign m_axis_tlast  = (occ_q != 3'd0) && last_s;
  assign busy          = (state_q != IDLE) || (occ_q != 3'd0) || inflight_q;
  assign beat_count    = beat_count_q;
  assign pkt_count     = pkt_count_q;

endmodule
